// File: rtl/dl_probe_scheduler.sv
// Deadlock probe scheduler: waits for a stable blocked set, launches a probe
// token from a round-robin-selected blocked process, walks the wait-for graph
// one hop per cycle, and holds a closed cycle through the origin until the
// report unit clears it.
module dl_probe_scheduler #(
    parameter int unsigned PROC_NUM      = 4,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic                         dl_clock,
    input  logic                         dl_reset,
    input  logic                         enable,
    input  logic [PROC_NUM-1:0]          dl_blocked,
    input  logic [PROC_NUM*PROC_NUM-1:0] dl_dep,
    input  logic                         token_clear,
    output logic [PROC_NUM-1:0]          dl_in_vec,
    output logic [PROC_NUM-1:0]          token_origin,
    output logic                         loop_found,
    output logic                         busy
);

    localparam int unsigned P     = PROC_NUM;
    localparam int unsigned IDX_W = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned HOP_W = $clog2(P) + 1;
    localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HOP_W-1:0] HOPS_LAST   = HOP_W'(P - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LAUNCH,
        ST_WALK,
        ST_HOLD
    } state_e;

    state_e           state_q;
    logic [P-1:0]     blk_snap_q;
    logic [CNT_W-1:0] settle_cnt_q;
    logic [IDX_W-1:0] holder_q;
    logic [IDX_W-1:0] origin_q;
    logic [P-1:0]     visited_q;
    logic [HOP_W-1:0] hops_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [P-1:0]     dl_in_vec_q;
    logic [P-1:0]     token_origin_q;
    logic             loop_found_q;
    logic             busy_q;

    logic [P-1:0]     dep_row_c;
    logic [P-1:0]     next_cand_c;
    logic             next_found_c;
    logic [IDX_W-1:0] next_idx_d;
    logic [IDX_W-1:0] launch_idx_d;
    logic [IDX_W-1:0] rr_ptr_d;
    logic             abort_c;
    logic             to_idle_c;

    // One-hot vector for a process index.
    function automatic logic [P-1:0] onehot(input logic [IDX_W-1:0] idx);
        return P'(1) << idx;
    endfunction

    // First requester at or after ptr, wrapping around the process ring.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [P-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        logic [IDX_W-1:0] cand;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < P; k++) begin
            cand = IDX_W'((32'(ptr) + 32'(k)) % P);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Wait-for row of the current holder, restricted to blocked processes.
    always_comb begin
        dep_row_c = '0;
        for (int unsigned i = 0; i < P; i++) begin
            if (holder_q == IDX_W'(i)) begin
                dep_row_c = dl_dep[i*P +: P];
            end
        end
        next_cand_c = dep_row_c & blk_snap_q;
    end

    // Lowest-index successor of the holder.
    always_comb begin
        next_found_c = |next_cand_c;
        next_idx_d   = '0;
        for (int j = int'(P) - 1; j >= 0; j--) begin
            if (next_cand_c[j]) begin
                next_idx_d = IDX_W'(j);
            end
        end
    end

    // Origin selection and the round-robin pointer that follows it.
    always_comb begin
        launch_idx_d = rr_pick(blk_snap_q, rr_ptr_q);
        rr_ptr_d     = IDX_W'((32'(launch_idx_d) + 32'd1) % P);
    end

    // Any exit back to IDLE; abort outranks every other transition.
    always_comb begin
        abort_c   = ~enable | (dl_blocked != blk_snap_q);
        to_idle_c = 1'b0;
        unique case (state_q)
            ST_SETTLE, ST_LAUNCH: to_idle_c = abort_c;
            ST_WALK: to_idle_c = abort_c | ~next_found_c |
                                 ((next_idx_d != origin_q) && (hops_q == HOPS_LAST));
            ST_HOLD: to_idle_c = abort_c | token_clear;
            default: to_idle_c = 1'b0;
        endcase
    end

    // Probe FSM with registered outputs.
    always_ff @(posedge dl_clock or negedge dl_reset) begin
        if (!dl_reset) begin
            state_q        <= ST_IDLE;
            blk_snap_q     <= '0;
            settle_cnt_q   <= '0;
            holder_q       <= '0;
            origin_q       <= '0;
            visited_q      <= '0;
            hops_q         <= '0;
            rr_ptr_q       <= '0;
            dl_in_vec_q    <= '0;
            token_origin_q <= '0;
            loop_found_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            loop_found_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (enable && (|dl_blocked)) begin
                        blk_snap_q   <= dl_blocked;
                        settle_cnt_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt_q <= settle_cnt_q + CNT_W'(1);
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    origin_q       <= launch_idx_d;
                    holder_q       <= launch_idx_d;
                    visited_q      <= onehot(launch_idx_d);
                    hops_q         <= '0;
                    rr_ptr_q       <= rr_ptr_d;
                    dl_in_vec_q    <= onehot(launch_idx_d);
                    token_origin_q <= onehot(launch_idx_d);
                    state_q        <= ST_WALK;
                end
                ST_WALK: begin
                    if (next_found_c && (next_idx_d == origin_q)) begin
                        dl_in_vec_q  <= visited_q;
                        loop_found_q <= 1'b1;
                        state_q      <= ST_HOLD;
                    end else begin
                        holder_q    <= next_idx_d;
                        visited_q   <= visited_q | onehot(next_idx_d);
                        hops_q      <= hops_q + HOP_W'(1);
                        dl_in_vec_q <= onehot(next_idx_d);
                    end
                end
                ST_HOLD: begin
                    dl_in_vec_q <= visited_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Exit to IDLE overrides whatever the state branch scheduled.
            if (to_idle_c) begin
                state_q        <= ST_IDLE;
                visited_q      <= '0;
                dl_in_vec_q    <= '0;
                token_origin_q <= '0;
                loop_found_q   <= 1'b0;
                busy_q         <= 1'b0;
            end
        end
    end

    assign dl_in_vec    = dl_in_vec_q;
    assign token_origin = token_origin_q;
    assign loop_found   = loop_found_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_dl_probe_scheduler.sv
// Directed bench for dl_probe_scheduler with PROC_NUM=4, STABLE_CYCLES=4.
module tb_dl_probe_scheduler;

    localparam int unsigned PN = 4;
    localparam int unsigned SC = 4;

    logic          dl_clock;
    logic          dl_reset;
    logic          enable;
    logic [PN-1:0] dl_blocked;
    logic [PN*PN-1:0] dl_dep;
    logic          token_clear;
    logic [PN-1:0] dl_in_vec;
    logic [PN-1:0] token_origin;
    logic          loop_found;
    logic          busy;

    int vectors;
    int miscompares;

    dl_probe_scheduler #(.PROC_NUM(PN), .STABLE_CYCLES(SC)) dut (
        .dl_clock     (dl_clock),
        .dl_reset     (dl_reset),
        .enable       (enable),
        .dl_blocked   (dl_blocked),
        .dl_dep       (dl_dep),
        .token_clear  (token_clear),
        .dl_in_vec    (dl_in_vec),
        .token_origin (token_origin),
        .loop_found   (loop_found),
        .busy         (busy)
    );

    initial dl_clock = 1'b0;
    always #5 dl_clock = ~dl_clock;

    // Advance one active edge and settle past it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge dl_clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] vec, input logic [3:0] org,
                             input logic lf, input logic bz);
        check({tag, ".dl_in_vec"}, 32'(dl_in_vec), 32'(vec));
        check({tag, ".token_origin"}, 32'(token_origin), 32'(org));
        check({tag, ".loop_found"}, 32'(loop_found), 32'(lf));
        check({tag, ".busy"}, 32'(busy), 32'(bz));
    endtask

    // Pulse reset between edges so rr_ptr restarts at 0.
    task automatic do_reset();
        dl_reset = 1'b0;
        #1;
        check_out("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
        dl_reset = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        dl_reset    = 1'b0;
        enable      = 1'b0;
        dl_blocked  = '0;
        dl_dep      = '0;
        token_clear = 1'b0;
        tick(2);
        check_out("por", 4'b0000, 4'b0000, 1'b0, 1'b0);
        dl_reset = 1'b1;

        // Two-process loop 0<->1, origin 0.
        dl_blocked = 4'b0011;
        dl_dep     = 16'h0012;
        enable     = 1'b1;
        tick(1);
        check_out("t1.settle0", 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick(3);
        check_out("t1.settle3", 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick(1);
        check_out("t1.launch", 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick(1);
        check_out("t1.walk0", 4'b0001, 4'b0001, 1'b0, 1'b1);
        tick(1);
        check_out("t1.walk1", 4'b0010, 4'b0001, 1'b0, 1'b1);
        tick(1);
        check_out("t1.hold", 4'b0011, 4'b0001, 1'b1, 1'b1);
        tick(1);
        check_out("t1.hold2", 4'b0011, 4'b0001, 1'b0, 1'b1);
        token_clear = 1'b1;
        tick(1);
        token_clear = 1'b0;
        check_out("t1.clear", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Same loop, origin rotated to 1.
        tick(1);
        check_out("t2.settle0", 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick(5);
        check_out("t2.walk0", 4'b0010, 4'b0010, 1'b0, 1'b1);
        tick(1);
        check_out("t2.walk1", 4'b0001, 4'b0010, 1'b0, 1'b1);
        tick(1);
        check_out("t2.hold", 4'b0011, 4'b0010, 1'b1, 1'b1);

        // Disable while holding: next edge back to idle with no pulse.
        enable = 1'b0;
        tick(1);
        check_out("t6.disable", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Chain 0->1->2->3 ending at unblocked process 3.
        do_reset();
        dl_blocked = 4'b0111;
        dl_dep     = 16'h0842;
        enable     = 1'b1;
        tick(6);
        check_out("t3.walk0", 4'b0001, 4'b0001, 1'b0, 1'b1);
        tick(1);
        check_out("t3.walk1", 4'b0010, 4'b0001, 1'b0, 1'b1);
        tick(1);
        check_out("t3.walk2", 4'b0100, 4'b0001, 1'b0, 1'b1);
        tick(1);
        check_out("t3.end", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Loop 2<->3 not through origin 1, then found from origin 2.
        do_reset();
        dl_blocked = 4'b1110;
        dl_dep     = 16'h4840;
        tick(6);
        check_out("t4.walk0", 4'b0010, 4'b0010, 1'b0, 1'b1);
        tick(1);
        check_out("t4.walk1", 4'b0100, 4'b0010, 1'b0, 1'b1);
        tick(1);
        check_out("t4.walk2", 4'b1000, 4'b0010, 1'b0, 1'b1);
        tick(1);
        check_out("t4.walk3", 4'b0100, 4'b0010, 1'b0, 1'b1);
        tick(1);
        check_out("t4.hoplimit", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(6);
        check_out("t4.p2walk0", 4'b0100, 4'b0100, 1'b0, 1'b1);
        tick(1);
        check_out("t4.p2walk1", 4'b1000, 4'b0100, 1'b0, 1'b1);
        tick(1);
        check_out("t4.p2hold", 4'b1100, 4'b0100, 1'b1, 1'b1);

        // Asynchronous reset while holding takes effect before the next edge.
        dl_reset = 1'b0;
        #1;
        check_out("t6.reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
        dl_reset = 1'b1;
        enable   = 1'b0;

        // Blocked set changes during settle: abort and resettle on new snapshot.
        tick(1);
        dl_blocked = 4'b0011;
        dl_dep     = 16'h0012;
        enable     = 1'b1;
        tick(2);
        check_out("t5.settle1", 4'b0000, 4'b0000, 1'b0, 1'b1);
        dl_blocked = 4'b0001;
        tick(1);
        check_out("t5.abort", 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(1);
        check_out("t5.resettle", 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick(5);
        check_out("t5.walk0", 4'b0001, 4'b0001, 1'b0, 1'b1);
        tick(1);
        check_out("t5.end", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Self-loop on process 2; token_clear outside HOLD has no effect.
        do_reset();
        dl_blocked  = 4'b0100;
        dl_dep      = 16'h0400;
        token_clear = 1'b1;
        tick(6);
        check_out("sl.walk0", 4'b0100, 4'b0100, 1'b0, 1'b1);
        token_clear = 1'b0;
        tick(1);
        check_out("sl.hold", 4'b0100, 4'b0100, 1'b1, 1'b1);
        tick(1);
        check_out("sl.hold2", 4'b0100, 4'b0100, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
